fazyrv_seq: RTL and testbench

Parametrised control sequencer for the bit-serial FazyRV core. It is the next-generation instruction-part controller. It walks each instruction through fetch, a parameterised register-file read latency, one or two serial data passes, memory acknowledge and shift phases. Unlike the previous controller, it adds:
- a bus timeout with error reporting,
- interrupt acceptance at instruction boundaries,
- a dedicated trap pass.

It sits between the decoder/datapath and the Wishbone instruction and data ports.

---
 rtl/fazyrv_pkg.sv | 25 ++
 rtl/fazyrv_seq_tmo.sv | 44 ++++
 rtl/fazyrv_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_fazyrv_seq.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fazyrv_pkg.sv
// fazyrv_pkg: shared types and helpers for the FazyRV control sequencer.
//   seq_state_t     - sequencer phase encoding
//   rf_rstb_cycles  - number of decode cycles that carry a RAM read strobe
//   ERR_SRC_*       - err_src_o encoding
package fazyrv_pkg;

  typedef enum logic [2:0] {
    ST_IFETCH = 3'd0,
    ST_DECODE = 3'd1,
    ST_ICYC1  = 3'd2,
    ST_ICYC2  = 3'd3,
    ST_ACK    = 3'd4,
    ST_SHIFT  = 3'd5,
    ST_TRAP   = 3'd6
  } seq_state_t;

  localparam logic ERR_SRC_IMEM = 1'b0;
  localparam logic ERR_SRC_DMEM = 1'b1;

  // A RAM register file needs at most two read strobes (rs1, rs2).
  function automatic int rf_rstb_cycles(input int rf_dly);
    return (rf_dly < 2) ? rf_dly : 2;
  endfunction

endpackage

// File: rtl/fazyrv_seq_tmo.sv
// fazyrv_seq_tmo: bus wait counter.
//   clk_i, rst_in : clock, async active-low reset
//   run_i         : count this cycle (sequencer waits on a bus)
//   clr_i         : restart from 0 (not waiting, or leaving the wait state)
//   expired_o     : counter has reached TIMEOUT while running
// TIMEOUT = 0 removes the counter entirely.
module fazyrv_seq_tmo #(
  parameter int TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_in,
  input  logic run_i,
  input  logic clr_i,
  output logic expired_o
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_tmo;
      assign unused_tmo = ^{clk_i, rst_in, run_i, clr_i};
      assign expired_o  = 1'b0;
    end else begin : g_on
      localparam int TW = $clog2(TIMEOUT + 1);
      localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

      logic [TW-1:0] cnt_q, cnt_d;

      // Saturates at TIMEOUT so a stalled sequencer never wraps back to 0.
      always_comb begin
        cnt_d = cnt_q;
        if (clr_i)                      cnt_d = '0;
        else if (run_i && cnt_q != TMAX) cnt_d = cnt_q + 1'b1;
      end

      always_ff @(posedge clk_i or negedge rst_in) begin
        if (!rst_in) cnt_q <= '0;
        else         cnt_q <= cnt_d;
      end

      assign expired_o = run_i & (cnt_q == TMAX);
    end
  endgenerate

endmodule

// File: rtl/fazyrv_seq.sv
// fazyrv_seq: instruction-part control sequencer for the bit-serial FazyRV.
// Walks each instruction through IFETCH, DECODE (RF read latency), one or
// two serial passes, data-bus ACK and SHIFT, plus a TRAP pass entered on a
// bus timeout or an interrupt taken at an instruction boundary.
// Ports:
//   clk_i, rst_in           : clock, async active-low reset
//   abort_i, pc_noinc_i     : abort after ICYC1/ACK, suppress PC increment
//   any_*_i                 : decoded instruction class
//   shft_done_i, hlt_res_i  : shift finished, freeze counter in ICYC1
//   irq_i                   : level interrupt request
//   imem_*/dmem_*           : Wishbone strobe/ack handshakes
//   lsb_o, msb_o            : LSB / MSB chunk at next edge
//   pc_inc_o, rf_ram_*_o    : PC increment, RAM RF strobes
//   cyc_*_o                 : phase flags
//   hlt_*_o                 : hold controls
//   irq_ack_o, bus_err_o    : single-cycle event pulses, err_src_o with bus_err_o
//   icyc_o                  : chunk index within the pass
module fazyrv_seq
  import fazyrv_pkg::*;
#(
  parameter int CHUNKSIZE = 2,
  parameter int REG_WIDTH = 32,
  parameter int CPI       = REG_WIDTH / CHUNKSIZE,
  parameter int RF_DLY    = 1,
  parameter int MEMDLY1   = 0,
  parameter int TIMEOUT   = 255,
  parameter int IRQ_EN    = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_in,
  input  logic                    abort_i,
  input  logic                    pc_noinc_i,
  input  logic                    any_jmp_i,
  input  logic                    any_br_i,
  input  logic                    any_ld_i,
  input  logic                    any_st_i,
  input  logic                    any_shft_i,
  input  logic                    any_slt_i,
  input  logic                    any_csr_i,
  input  logic                    shft_done_i,
  input  logic                    hlt_res_i,
  input  logic                    irq_i,
  output logic                    imem_stb_o,
  input  logic                    imem_ack_i,
  output logic                    dmem_stb_o,
  input  logic                    dmem_ack_i,
  output logic                    lsb_o,
  output logic                    msb_o,
  output logic                    pc_inc_o,
  output logic                    rf_ram_rstb_o,
  output logic                    rf_ram_wstb_o,
  output logic                    cyc_two_o,
  output logic                    cyc_ack_o,
  output logic                    cyc_shft_o,
  output logic                    cyc_trap_o,
  output logic                    cyc_two_shift_next_o,
  output logic                    hlt_regs_o,
  output logic                    hlt_spm_a_o,
  output logic                    hlt_imm_o,
  output logic                    irq_ack_o,
  output logic                    bus_err_o,
  output logic                    err_src_o,
  output logic [$clog2(CPI)-1:0]  icyc_o
);

  localparam int CW = $clog2(CPI);
  localparam logic [CW-1:0] CLAST = CW'(CPI - 1);

  seq_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lsb_q;

  logic last, imem_ok, tmo_run, tmo_clr, tmo_exp;
  logic msb, irq_take, berr, hlt_imm, to_if;

  assign last    = (cnt_q == CLAST);
  assign imem_ok = (MEMDLY1 != 0) ? 1'b1 : imem_ack_i;

  // Count only while actually waiting on a bus; any state change restarts it.
  assign tmo_run = ((state_q == ST_IFETCH) && (MEMDLY1 == 0)) || (state_q == ST_ACK);
  assign tmo_clr = ~tmo_run | (state_d != state_q);

  fazyrv_seq_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk_i     (clk_i),
    .rst_in    (rst_in),
    .run_i     (tmo_run),
    .clr_i     (tmo_clr),
    .expired_o (tmo_exp)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    msb      = 1'b0;
    irq_take = 1'b0;
    berr     = 1'b0;
    hlt_imm  = 1'b1;
    to_if    = 1'b0;   // regular (non-abort) return to IFETCH, IRQ-eligible
    case (state_q)
      ST_IFETCH: begin
        msb   = 1'b1;
        cnt_d = '0;
        if (imem_ok)      state_d = (RF_DLY == 0) ? ST_ICYC1 : ST_DECODE;
        else if (tmo_exp) begin
          berr    = 1'b1;
          state_d = ST_TRAP;
        end
      end
      ST_DECODE: begin
        msb = 1'b1;
        if (int'(cnt_q) >= RF_DLY - 1) begin
          cnt_d   = '0;
          state_d = ST_ICYC1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ICYC1: begin
        hlt_imm = any_br_i;
        if (!hlt_res_i) cnt_d = cnt_q + 1'b1;
        if (last) begin
          msb = 1'b1;
          // A frozen counter holds the pass on its last chunk.
          if (!hlt_res_i) begin
            cnt_d = '0;
            if (abort_i)         state_d = ST_IFETCH;
            else if (any_shft_i) state_d = shft_done_i ? ST_ICYC2 : ST_SHIFT;
            else if (any_ld_i)   state_d = ST_ACK;
            else if (any_jmp_i | any_br_i | any_st_i | any_slt_i | any_csr_i)
                                 state_d = ST_ICYC2;
            else                 to_if = 1'b1;
          end
        end
      end
      ST_ICYC2: begin
        hlt_imm = 1'b0;
        cnt_d   = cnt_q + 1'b1;
        if (last) begin
          msb   = 1'b1;
          cnt_d = '0;
          if (any_st_i) state_d = ST_ACK;
          else          to_if = 1'b1;
        end
      end
      ST_ACK: begin
        cnt_d = '0;
        msb   = dmem_ack_i;
        if (abort_i) state_d = ST_IFETCH;
        else if (dmem_ack_i) begin
          if (any_ld_i) state_d = shft_done_i ? ST_ICYC2 : ST_SHIFT;
          else          to_if = 1'b1;
        end else if (tmo_exp) begin
          berr    = 1'b1;
          state_d = ST_TRAP;
        end
      end
      ST_SHIFT: begin
        cnt_d = '0;
        if (shft_done_i) begin
          msb     = 1'b1;
          state_d = ST_ICYC2;
        end
      end
      ST_TRAP: begin
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          msb     = 1'b1;
          cnt_d   = '0;
          state_d = ST_IFETCH;   // no IRQ check on trap exit
        end
      end
      default: begin
        msb     = 1'b1;
        cnt_d   = '0;
        state_d = ST_IFETCH;
      end
    endcase
    // Instruction boundary: a pending interrupt diverts into the trap pass.
    if (to_if) begin
      if ((IRQ_EN != 0) && irq_i) begin
        irq_take = 1'b1;
        state_d  = ST_TRAP;
      end else begin
        state_d = ST_IFETCH;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IFETCH;
      cnt_q   <= '0;
      lsb_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lsb_q   <= msb;
    end
  end

  assign msb_o       = msb;
  assign lsb_o       = lsb_q;
  assign icyc_o      = cnt_q;
  assign imem_stb_o  = (state_q == ST_IFETCH);
  assign dmem_stb_o  = (state_q == ST_ACK);
  assign cyc_two_o   = (state_q == ST_ICYC2);
  assign cyc_ack_o   = (state_q == ST_ACK);
  assign cyc_shft_o  = (state_q == ST_SHIFT);
  assign cyc_trap_o  = (state_q == ST_TRAP);
  assign cyc_two_shift_next_o = (state_d == ST_ICYC2) | (state_d == ST_SHIFT);

  // Branches, loads and stores update the PC in the second pass.
  assign pc_inc_o = ~pc_noinc_i & lsb_q &
                    (state_q == ((any_br_i | any_ld_i | any_st_i) ? ST_ICYC2 : ST_ICYC1));

  assign rf_ram_rstb_o = (RF_DLY > 0) && (state_q == ST_DECODE) &&
                         (int'(cnt_q) < rf_rstb_cycles(RF_DLY));
  assign rf_ram_wstb_o = (RF_DLY > 0) &&
                         ((state_q == ST_IFETCH) ||
                          ((state_q == ST_ICYC2) && lsb_q && any_csr_i));

  assign hlt_regs_o  = ~((state_q == ST_ICYC1) | (state_q == ST_ICYC2) | (state_q == ST_TRAP));
  assign hlt_spm_a_o = ~((state_q == ST_ICYC1) & ~(any_shft_i & msb));
  assign hlt_imm_o   = hlt_imm;

  assign irq_ack_o = irq_take;
  assign bus_err_o = berr;
  assign err_src_o = berr ? ((state_q == ST_ACK) ? ERR_SRC_DMEM : ERR_SRC_IMEM) : 1'b0;

endmodule

// File: tb/tb_fazyrv_seq.sv
// Bench for fazyrv_seq (CHUNKSIZE=2 -> 16 cycles/pass, RF_DLY=2, TIMEOUT=4,
// IRQ_EN=1). A monitor folds the observed phase sequence into (phase,length)
// segments; each test pushes the expected segments up front and compares.
module tb_fazyrv_seq;
  localparam int CPI = 16;
  localparam int P_IF = 0, P_DE = 1, P_C1 = 2, P_C2 = 3, P_AK = 4, P_SH = 5, P_TR = 6;

  logic clk = 1'b0;
  logic rst_in = 1'b0;
  logic abort_i = 0, pc_noinc_i = 0, any_jmp_i = 0, any_br_i = 0, any_ld_i = 0;
  logic any_st_i = 0, any_shft_i = 0, any_slt_i = 0, any_csr_i = 0;
  logic shft_done_i = 0, hlt_res_i = 0, irq_i = 0, imem_ack_i = 0, dmem_ack_i = 0;
  logic imem_stb_o, dmem_stb_o, lsb_o, msb_o, pc_inc_o, rf_ram_rstb_o, rf_ram_wstb_o;
  logic cyc_two_o, cyc_ack_o, cyc_shft_o, cyc_trap_o, cyc_two_shift_next_o;
  logic hlt_regs_o, hlt_spm_a_o, hlt_imm_o, irq_ack_o, bus_err_o, err_src_o;
  logic [3:0] icyc_o;

  fazyrv_seq #(.CHUNKSIZE(2), .REG_WIDTH(32), .RF_DLY(2), .MEMDLY1(0),
               .TIMEOUT(4), .IRQ_EN(1)) dut (
    .clk_i(clk), .rst_in(rst_in), .abort_i(abort_i), .pc_noinc_i(pc_noinc_i),
    .any_jmp_i(any_jmp_i), .any_br_i(any_br_i), .any_ld_i(any_ld_i),
    .any_st_i(any_st_i), .any_shft_i(any_shft_i), .any_slt_i(any_slt_i),
    .any_csr_i(any_csr_i), .shft_done_i(shft_done_i), .hlt_res_i(hlt_res_i),
    .irq_i(irq_i), .imem_stb_o(imem_stb_o), .imem_ack_i(imem_ack_i),
    .dmem_stb_o(dmem_stb_o), .dmem_ack_i(dmem_ack_i), .lsb_o(lsb_o), .msb_o(msb_o),
    .pc_inc_o(pc_inc_o), .rf_ram_rstb_o(rf_ram_rstb_o), .rf_ram_wstb_o(rf_ram_wstb_o),
    .cyc_two_o(cyc_two_o), .cyc_ack_o(cyc_ack_o), .cyc_shft_o(cyc_shft_o),
    .cyc_trap_o(cyc_trap_o), .cyc_two_shift_next_o(cyc_two_shift_next_o),
    .hlt_regs_o(hlt_regs_o), .hlt_spm_a_o(hlt_spm_a_o), .hlt_imm_o(hlt_imm_o),
    .irq_ack_o(irq_ack_o), .bus_err_o(bus_err_o), .err_src_o(err_src_o),
    .icyc_o(icyc_o));

  always #10 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int exp_ph[$], exp_len[$], obs_ph[$], obs_len[$];
  int n_exp = 0;
  int imem_lat = 1, dmem_lat = 0, shft_lat = 1;
  int pc_cnt, pc_ph, pc_idx, pc_trap, rstb_cnt;
  int irq_cnt, irq_ph, irq_idx, berr_cnt, berr_ph, berr_idx;
  logic berr_src;

  function automatic int phase_of();
    if (imem_stb_o)       return P_IF;
    else if (dmem_stb_o)  return P_AK;
    else if (cyc_two_o)   return P_C2;
    else if (cyc_shft_o)  return P_SH;
    else if (cyc_trap_o)  return P_TR;
    else if (!hlt_regs_o) return P_C1;
    return P_DE;
  endfunction

  // Bus/shift responders: ack on the lat-th cycle of the waiting phase.
  initial begin
    int iw, dw, sw;
    iw = 0; dw = 0; sw = 0;
    forever begin
      @(posedge clk); #2;
      if (!rst_in) begin
        iw = 0; dw = 0; sw = 0;
      end else begin
        iw = imem_stb_o ? iw + 1 : 0;
        dw = dmem_stb_o ? dw + 1 : 0;
        sw = cyc_shft_o ? sw + 1 : 0;
      end
      imem_ack_i  = rst_in && imem_stb_o && (iw == imem_lat);
      dmem_ack_i  = rst_in && dmem_stb_o && (dw == dmem_lat);
      shft_done_i = rst_in && cyc_shft_o && (sw == shft_lat);
    end
  end

  // Monitor: phase segments plus event positions inside the expected window.
  initial begin
    int cur, len, p;
    cur = -1; len = 0;
    forever begin
      @(posedge clk); #3;
      if (!rst_in) begin
        cur = -1; len = 0;
      end else begin
        p = phase_of();
        if (p == cur) len++;
        else begin
          if (cur >= 0) begin obs_ph.push_back(cur); obs_len.push_back(len); end
          cur = p; len = 1;
        end
        if (obs_ph.size() < n_exp) begin
          if (pc_inc_o) begin pc_cnt++; pc_ph = p; pc_idx = len - 1; if (p == P_TR) pc_trap++; end
          if (rf_ram_rstb_o) rstb_cnt++;
          if (irq_ack_o) begin irq_cnt++; irq_ph = p; irq_idx = len - 1; end
          if (bus_err_o) begin berr_cnt++; berr_ph = p; berr_idx = len - 1; berr_src = err_src_o; end
        end
      end
    end
  end

  task automatic set_cls(input logic jmp, br, ld, st, shft);
    any_jmp_i = jmp; any_br_i = br; any_ld_i = ld; any_st_i = st; any_shft_i = shft;
    any_slt_i = 0; any_csr_i = 0;
  endtask

  // Asserts reset and clears scoreboard state; reset stays low on return.
  task automatic do_reset();
    @(posedge clk); #1;
    rst_in = 1'b0;
    exp_ph.delete(); exp_len.delete(); obs_ph.delete(); obs_len.delete();
    n_exp = 0; pc_cnt = 0; pc_ph = -1; pc_idx = -1; pc_trap = 0; rstb_cnt = 0;
    irq_cnt = 0; irq_ph = -1; irq_idx = -1; berr_cnt = 0; berr_ph = -1; berr_idx = -1;
    berr_src = 1'bx;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_rst();
    @(posedge clk); #1;
    rst_in = 1'b1;
  endtask

  task automatic push_seg(input int p, input int l);
    exp_ph.push_back(p); exp_len.push_back(l);
    n_exp = exp_ph.size();
  endtask

  task automatic wait_segs(output bit ok);
    ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #4;
      if (obs_ph.size() >= n_exp) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    @(posedge clk); #4;
    n_chk++; if (imem_stb_o !== 1'b1) begin n_fail++; $display("FAIL rst imem_stb: got %b want 1", imem_stb_o); end
    n_chk++; if (msb_o !== 1'b1) begin n_fail++; $display("FAIL rst msb: got %b want 1", msb_o); end
    n_chk++; if (lsb_o !== 1'b0) begin n_fail++; $display("FAIL rst lsb: got %b want 0", lsb_o); end
    n_chk++; if (rf_ram_wstb_o !== 1'b1) begin n_fail++; $display("FAIL rst wstb: got %b want 1", rf_ram_wstb_o); end
    n_chk++; if (hlt_regs_o !== 1'b1 || hlt_imm_o !== 1'b1) begin n_fail++; $display("FAIL rst hlt: got regs %b imm %b want 1 1", hlt_regs_o, hlt_imm_o); end
    n_chk++; if (icyc_o !== 4'd0) begin n_fail++; $display("FAIL rst icyc: got %0d want 0", icyc_o); end
    n_chk++;
    if ({dmem_stb_o, pc_inc_o, rf_ram_rstb_o, cyc_two_o, cyc_ack_o, cyc_shft_o, cyc_trap_o,
         irq_ack_o, bus_err_o, err_src_o} !== 10'b0) begin
      n_fail++; $display("FAIL rst others: got %b want 0", {dmem_stb_o, pc_inc_o, rf_ram_rstb_o,
        cyc_two_o, cyc_ack_o, cyc_shft_o, cyc_trap_o, irq_ack_o, bus_err_o, err_src_o});
    end
  endtask

  task automatic test_alu();
    bit ok;
    set_cls(0, 0, 0, 0, 0); imem_lat = 1; abort_i = 0; irq_i = 0;
    do_reset();
    push_seg(P_IF, 1); push_seg(P_DE, 2); push_seg(P_C1, CPI); push_seg(P_IF, 1);
    release_rst();
    wait_segs(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL alu timeout: got %0d segs want %0d", obs_ph.size(), n_exp); end
    while (exp_ph.size() > 0 && obs_ph.size() > 0) begin
      int e, el, o, ol;
      e = exp_ph.pop_front(); el = exp_len.pop_front(); o = obs_ph.pop_front(); ol = obs_len.pop_front();
      n_chk++; if (o !== e || ol !== el) begin n_fail++; $display("FAIL alu seg: got ph %0d len %0d want ph %0d len %0d", o, ol, e, el); end
    end
    n_chk++; if (pc_cnt !== 1 || pc_ph !== P_C1 || pc_idx !== 0) begin n_fail++; $display("FAIL alu pc_inc: got n%0d ph%0d idx%0d want n1 ph%0d idx0", pc_cnt, pc_ph, pc_idx, P_C1); end
    n_chk++; if (rstb_cnt !== 2) begin n_fail++; $display("FAIL alu rstb: got %0d want 2", rstb_cnt); end
  endtask

  task automatic test_load();
    bit ok;
    set_cls(0, 0, 1, 0, 0); imem_lat = 1; dmem_lat = 5; shft_lat = 3;
    do_reset();
    push_seg(P_IF, 1); push_seg(P_DE, 2); push_seg(P_C1, CPI); push_seg(P_AK, 5);
    push_seg(P_SH, 3); push_seg(P_C2, CPI); push_seg(P_IF, 1);
    release_rst();
    wait_segs(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL load timeout: got %0d segs want %0d", obs_ph.size(), n_exp); end
    while (exp_ph.size() > 0 && obs_ph.size() > 0) begin
      int e, el, o, ol;
      e = exp_ph.pop_front(); el = exp_len.pop_front(); o = obs_ph.pop_front(); ol = obs_len.pop_front();
      n_chk++; if (o !== e || ol !== el) begin n_fail++; $display("FAIL load seg: got ph %0d len %0d want ph %0d len %0d", o, ol, e, el); end
    end
    n_chk++; if (rstb_cnt !== 2) begin n_fail++; $display("FAIL load rstb: got %0d want 2", rstb_cnt); end
    n_chk++; if (pc_cnt !== 1 || pc_ph !== P_C2 || pc_idx !== 0) begin n_fail++; $display("FAIL load pc_inc: got n%0d ph%0d idx%0d want n1 ph%0d idx0", pc_cnt, pc_ph, pc_idx, P_C2); end
    n_chk++; if (berr_cnt !== 0) begin n_fail++; $display("FAIL load bus_err: got %0d want 0", berr_cnt); end
  endtask

  task automatic test_timeout();
    bit ok;
    set_cls(0, 0, 0, 1, 0); imem_lat = 1; dmem_lat = 0;
    do_reset();
    push_seg(P_IF, 1); push_seg(P_DE, 2); push_seg(P_C1, CPI); push_seg(P_C2, CPI);
    push_seg(P_AK, 5); push_seg(P_TR, CPI); push_seg(P_IF, 1);
    release_rst();
    wait_segs(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL tmo timeout: got %0d segs want %0d", obs_ph.size(), n_exp); end
    while (exp_ph.size() > 0 && obs_ph.size() > 0) begin
      int e, el, o, ol;
      e = exp_ph.pop_front(); el = exp_len.pop_front(); o = obs_ph.pop_front(); ol = obs_len.pop_front();
      n_chk++; if (o !== e || ol !== el) begin n_fail++; $display("FAIL tmo seg: got ph %0d len %0d want ph %0d len %0d", o, ol, e, el); end
    end
    n_chk++; if (berr_cnt !== 1 || berr_ph !== P_AK || berr_idx !== 4) begin n_fail++; $display("FAIL tmo bus_err: got n%0d ph%0d idx%0d want n1 ph%0d idx4", berr_cnt, berr_ph, berr_idx, P_AK); end
    n_chk++; if (berr_src !== 1'b1) begin n_fail++; $display("FAIL tmo err_src: got %b want 1", berr_src); end
    n_chk++; if (pc_trap !== 0) begin n_fail++; $display("FAIL tmo pc_inc in trap: got %0d want 0", pc_trap); end
  endtask

  task automatic test_ack_on_expiry();
    bit ok;
    set_cls(0, 0, 0, 1, 0); imem_lat = 1; dmem_lat = 5;
    do_reset();
    push_seg(P_IF, 1); push_seg(P_DE, 2); push_seg(P_C1, CPI); push_seg(P_C2, CPI);
    push_seg(P_AK, 5); push_seg(P_IF, 1);
    release_rst();
    wait_segs(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL expiry timeout: got %0d segs want %0d", obs_ph.size(), n_exp); end
    while (exp_ph.size() > 0 && obs_ph.size() > 0) begin
      int e, el, o, ol;
      e = exp_ph.pop_front(); el = exp_len.pop_front(); o = obs_ph.pop_front(); ol = obs_len.pop_front();
      n_chk++; if (o !== e || ol !== el) begin n_fail++; $display("FAIL expiry seg: got ph %0d len %0d want ph %0d len %0d", o, ol, e, el); end
    end
    n_chk++; if (berr_cnt !== 0) begin n_fail++; $display("FAIL expiry bus_err: got %0d want 0", berr_cnt); end
  endtask

  task automatic test_irq();
    bit ok;
    set_cls(0, 1, 0, 0, 0); imem_lat = 1; abort_i = 0; irq_i = 0;
    do_reset();
    push_seg(P_IF, 1); push_seg(P_DE, 2); push_seg(P_C1, CPI); push_seg(P_C2, CPI);
    push_seg(P_TR, CPI); push_seg(P_IF, 1);
    release_rst();
    repeat (10) @(posedge clk);
    #1 irq_i = 1'b1;   // middle of ICYC1
    wait_segs(ok);
    irq_i = 1'b0;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL irq timeout: got %0d segs want %0d", obs_ph.size(), n_exp); end
    while (exp_ph.size() > 0 && obs_ph.size() > 0) begin
      int e, el, o, ol;
      e = exp_ph.pop_front(); el = exp_len.pop_front(); o = obs_ph.pop_front(); ol = obs_len.pop_front();
      n_chk++; if (o !== e || ol !== el) begin n_fail++; $display("FAIL irq seg: got ph %0d len %0d want ph %0d len %0d", o, ol, e, el); end
    end
    n_chk++; if (irq_cnt !== 1 || irq_ph !== P_C2 || irq_idx !== CPI - 1) begin n_fail++; $display("FAIL irq ack: got n%0d ph%0d idx%0d want n1 ph%0d idx%0d", irq_cnt, irq_ph, irq_idx, P_C2, CPI - 1); end
    n_chk++; if (pc_cnt !== 1 || pc_trap !== 0) begin n_fail++; $display("FAIL irq pc_inc: got n%0d trap%0d want n1 trap0", pc_cnt, pc_trap); end
  endtask

  task automatic test_irq_abort();
    bit ok;
    set_cls(0, 1, 0, 0, 0); imem_lat = 1; abort_i = 1; irq_i = 1;
    do_reset();
    push_seg(P_IF, 1); push_seg(P_DE, 2); push_seg(P_C1, CPI); push_seg(P_IF, 1);
    release_rst();
    wait_segs(ok);
    abort_i = 0; irq_i = 0;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL abort timeout: got %0d segs want %0d", obs_ph.size(), n_exp); end
    while (exp_ph.size() > 0 && obs_ph.size() > 0) begin
      int e, el, o, ol;
      e = exp_ph.pop_front(); el = exp_len.pop_front(); o = obs_ph.pop_front(); ol = obs_len.pop_front();
      n_chk++; if (o !== e || ol !== el) begin n_fail++; $display("FAIL abort seg: got ph %0d len %0d want ph %0d len %0d", o, ol, e, el); end
    end
    n_chk++; if (irq_cnt !== 0) begin n_fail++; $display("FAIL abort irq_ack: got %0d want 0", irq_cnt); end
  endtask

  task automatic test_reset_mid();
    bit found;
    set_cls(1, 0, 0, 0, 0); imem_lat = 1; irq_i = 1;
    do_reset();
    release_rst();
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #3;
      if (cyc_two_o === 1'b1 && icyc_o === 4'd7) begin found = 1; break; end
    end
    n_chk++; if (!found) begin n_fail++; $display("FAIL midrst reach: got no ICYC2 cycle 7 want reached"); end
    #3 rst_in = 1'b0;   // between clock edges
    #1;
    n_chk++; if (imem_stb_o !== 1'b1 || cyc_two_o !== 1'b0) begin n_fail++; $display("FAIL midrst state: got stb %b two %b want 1 0", imem_stb_o, cyc_two_o); end
    n_chk++; if (icyc_o !== 4'd0) begin n_fail++; $display("FAIL midrst icyc: got %0d want 0", icyc_o); end
    n_chk++; if (msb_o !== 1'b1 || lsb_o !== 1'b0 || hlt_regs_o !== 1'b1) begin n_fail++; $display("FAIL midrst flags: got msb %b lsb %b hlt %b want 1 0 1", msb_o, lsb_o, hlt_regs_o); end
    n_chk++; if (irq_ack_o !== 1'b0 || bus_err_o !== 1'b0 || pc_inc_o !== 1'b0) begin n_fail++; $display("FAIL midrst pulses: got irq %b berr %b pc %b want 0", irq_ack_o, bus_err_o, pc_inc_o); end
    irq_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_timeout();
    test_ack_on_expiry();
    test_irq();
    test_irq_abort();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
